// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter for a shared slave port.
// Uses round-robin grant on contention, holds the grant for the whole cycle, and errors a strobe when the slave wait times out.
module wshb_arbiter #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,

   input  logic                      m0_cyc,
   input  logic                      m0_stb,
   input  logic                      m0_we,
   input  logic [ADDR_W-1:0]         m0_adr,
   input  logic [8*DATA_BYTES-1:0]   m0_dat_ms,
   input  logic [DATA_BYTES-1:0]     m0_sel,
   input  logic [2:0]                m0_cti,
   input  logic [1:0]                m0_bte,
   output logic                      m0_ack,
   output logic                      m0_err,
   output logic                      m0_rty,
   output logic [8*DATA_BYTES-1:0]   m0_dat_sm,

   input  logic                      m1_cyc,
   input  logic                      m1_stb,
   input  logic                      m1_we,
   input  logic [ADDR_W-1:0]         m1_adr,
   input  logic [8*DATA_BYTES-1:0]   m1_dat_ms,
   input  logic [DATA_BYTES-1:0]     m1_sel,
   input  logic [2:0]                m1_cti,
   input  logic [1:0]                m1_bte,
   output logic                      m1_ack,
   output logic                      m1_err,
   output logic                      m1_rty,
   output logic [8*DATA_BYTES-1:0]   m1_dat_sm,

   output logic                      s_cyc,
   output logic                      s_stb,
   output logic                      s_we,
   output logic [ADDR_W-1:0]         s_adr,
   output logic [8*DATA_BYTES-1:0]   s_dat_ms,
   output logic [DATA_BYTES-1:0]     s_sel,
   output logic [2:0]                s_cti,
   output logic [1:0]                s_bte,
   input  logic                      s_ack,
   input  logic                      s_err,
   input  logic                      s_rty,
   input  logic [8*DATA_BYTES-1:0]   s_dat_sm,

   output logic [1:0]                gnt
);

   localparam int          DW        = 8*DATA_BYTES;
   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t            state_r;
   state_t            next_state_s;
   logic              last_grant_r;
   logic [15:0]       wait_cnt_r;
   logic [1:0]        gnt_r;

   logic              granted_s;
   logic              slave_rsp_s;
   logic              timeout_s;

   logic              route_cyc_s;
   logic              route_stb_s;
   logic              rsp0_ack_s;
   logic              rsp0_err_s;
   logic              rsp0_rty_s;
   logic              rsp1_ack_s;
   logic              rsp1_err_s;
   logic              rsp1_rty_s;

   assign granted_s   = (state_r == GRANT0) || (state_r == GRANT1);
   assign slave_rsp_s = s_ack | s_err | s_rty;
   assign timeout_s   = granted_s && (wait_cnt_r == TIMEOUT_C);

   // Next-state selection: round-robin from IDLE, hold the grant while the owner keeps cyc high
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (m0_cyc && m1_cyc) begin
               if (last_grant_r) begin
                  next_state_s = GRANT0;
               end else begin
                  next_state_s = GRANT1;
               end
            end else if (m0_cyc) begin
               next_state_s = GRANT0;
            end else if (m1_cyc) begin
               next_state_s = GRANT1;
            end else begin
               next_state_s = IDLE;
            end
         end
         GRANT0: begin
            if (m0_cyc) begin
               next_state_s = GRANT0;
            end else begin
               next_state_s = IDLE;
            end
         end
         GRANT1: begin
            if (m1_cyc) begin
               next_state_s = GRANT1;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, grant status and round-robin history registers
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         gnt_r        <= 2'b00;
      end else begin
         state_r <= next_state_s;
         gnt_r   <= {next_state_s == GRANT1, next_state_s == GRANT0};
         if ((state_r == IDLE) && (next_state_s == GRANT0)) begin
            last_grant_r <= 1'b0;
         end else if ((state_r == IDLE) && (next_state_s == GRANT1)) begin
            last_grant_r <= 1'b1;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Slave wait counter; cleared while idle so every grant starts from zero
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         wait_cnt_r <= 16'd0;
      end else if (!granted_s) begin
         wait_cnt_r <= 16'd0;
      end else if (slave_rsp_s || timeout_s) begin
         wait_cnt_r <= 16'd0;
      end else if (s_stb && (wait_cnt_r < TIMEOUT_C)) begin
         wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Zero-latency routing between the granted master and the slave
   always_comb begin
      route_cyc_s = 1'b0;
      route_stb_s = 1'b0;
      s_we        = 1'b0;
      s_adr       = '0;
      s_dat_ms    = '0;
      s_sel       = '0;
      s_cti       = 3'b000;
      s_bte       = 2'b00;
      rsp0_ack_s  = 1'b0;
      rsp0_err_s  = 1'b0;
      rsp0_rty_s  = 1'b0;
      rsp1_ack_s  = 1'b0;
      rsp1_err_s  = 1'b0;
      rsp1_rty_s  = 1'b0;
      m0_dat_sm   = '0;
      m1_dat_sm   = '0;
      case (state_r)
         GRANT0: begin
            route_cyc_s = m0_cyc;
            route_stb_s = m0_cyc & m0_stb;
            s_we        = m0_we;
            s_adr       = m0_adr;
            s_dat_ms    = m0_dat_ms;
            s_sel       = m0_sel;
            s_cti       = m0_cti;
            s_bte       = m0_bte;
            rsp0_ack_s  = s_ack;
            rsp0_err_s  = s_err | timeout_s;
            rsp0_rty_s  = s_rty;
            m0_dat_sm   = s_dat_sm;
         end
         GRANT1: begin
            route_cyc_s = m1_cyc;
            route_stb_s = m1_cyc & m1_stb;
            s_we        = m1_we;
            s_adr       = m1_adr;
            s_dat_ms    = m1_dat_ms;
            s_sel       = m1_sel;
            s_cti       = m1_cti;
            s_bte       = m1_bte;
            rsp1_ack_s  = s_ack;
            rsp1_err_s  = s_err | timeout_s;
            rsp1_rty_s  = s_rty;
            m1_dat_sm   = s_dat_sm;
         end
         default: begin
            route_cyc_s = 1'b0;
            route_stb_s = 1'b0;
         end
      endcase
   end

   // Reset kills handshakes immediately; a timeout drops the slave cycle for its error beat
   assign s_cyc  = route_cyc_s & sys_rst_n & ~timeout_s;
   assign s_stb  = route_stb_s & sys_rst_n & ~timeout_s;
   assign m0_ack = rsp0_ack_s & sys_rst_n;
   assign m0_err = rsp0_err_s & sys_rst_n;
   assign m0_rty = rsp0_rty_s & sys_rst_n;
   assign m1_ack = rsp1_ack_s & sys_rst_n;
   assign m1_err = rsp1_err_s & sys_rst_n;
   assign m1_rty = rsp1_rty_s & sys_rst_n;
   assign gnt    = gnt_r;

   logic unused_dw_s;
   assign unused_dw_s = (DW == 0);

endmodule

// File: tb/tb_wshb_arbiter.sv
// Vector-table and scoreboard bench for wshb_arbiter (TIMEOUT=4).
module tb_wshb_arbiter;

   localparam logic [31:0] M0_ADR = 32'h0000_0100;
   localparam logic [31:0] M0_DAT = 32'h1111_1111;
   localparam logic [3:0]  M0_SEL = 4'hF;
   localparam logic [2:0]  M0_CTI = 3'b000;
   localparam logic [1:0]  M0_BTE = 2'b00;
   localparam logic [31:0] M1_ADR = 32'h0000_0200;
   localparam logic [31:0] M1_DAT = 32'h2222_2222;
   localparam logic [3:0]  M1_SEL = 4'h3;
   localparam logic [2:0]  M1_CTI = 3'b010;
   localparam logic [1:0]  M1_BTE = 2'b01;
   localparam logic [31:0] S_DAT  = 32'hDEAD_BEEF;

   typedef struct packed {
      logic rst_n, c0, s0, w0, c1, s1, w1, ack, err, rty;
   } in_t;

   typedef struct packed {
      logic [1:0] gnt;
      logic scyc, sstb, swe, a0, e0, r0, a1, e1, r1;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        m0_cyc, m0_stb, m0_we;
   logic [31:0] m0_adr, m0_dat_ms;
   logic [3:0]  m0_sel;
   logic [2:0]  m0_cti;
   logic [1:0]  m0_bte;
   logic        m0_ack, m0_err, m0_rty;
   logic [31:0] m0_dat_sm;
   logic        m1_cyc, m1_stb, m1_we;
   logic [31:0] m1_adr, m1_dat_ms;
   logic [3:0]  m1_sel;
   logic [2:0]  m1_cti;
   logic [1:0]  m1_bte;
   logic        m1_ack, m1_err, m1_rty;
   logic [31:0] m1_dat_sm;
   logic        s_cyc, s_stb, s_we;
   logic [31:0] s_adr, s_dat_ms;
   logic [3:0]  s_sel;
   logic [2:0]  s_cti;
   logic [1:0]  s_bte;
   logic        s_ack, s_err, s_rty;
   logic [31:0] s_dat_sm;
   logic [1:0]  gnt;

   int   n_cmp = 0;
   int   n_bad = 0;
   out_t sb_q[$];
   vec_t tbl[20];

   wshb_arbiter #(.DATA_BYTES(4), .ADDR_W(32), .TIMEOUT(4)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
      .gnt(gnt)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish (got timeout, expected completion)");
      $fatal(1, "watchdog expired");
   end

   function automatic vec_t mkv(input logic [9:0] i, input logic [10:0] o);
      vec_t v;
      v.i = i;
      v.o = o;
      return v;
   endfunction

   task automatic chk(input string ph, input int idx, input string nm,
                      input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] %s: got %0h expected %0h", ph, idx, nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle
   task automatic apply(input string ph, input int idx, input vec_t v);
      out_t         e;
      logic [72:0]  rexp;
      logic [31:0]  d0exp;
      logic [31:0]  d1exp;
      @(posedge sys_clk);
      #1;
      sys_rst_n = v.i.rst_n;
      m0_cyc = v.i.c0; m0_stb = v.i.s0; m0_we = v.i.w0;
      m1_cyc = v.i.c1; m1_stb = v.i.s1; m1_we = v.i.w1;
      s_ack  = v.i.ack; s_err = v.i.err; s_rty = v.i.rty;
      sb_q.push_back(v.o);
      #2;
      e = sb_q.pop_front();
      case (e.gnt)
         2'b01:   rexp = {M0_ADR, M0_DAT, M0_SEL, M0_CTI, M0_BTE};
         2'b10:   rexp = {M1_ADR, M1_DAT, M1_SEL, M1_CTI, M1_BTE};
         default: rexp = '0;
      endcase
      d0exp = e.gnt[0] ? S_DAT : 32'h0;
      d1exp = e.gnt[1] ? S_DAT : 32'h0;
      chk(ph, idx, "gnt", 128'(gnt), 128'(e.gnt));
      chk(ph, idx, "s_cyc_stb_we", 128'({s_cyc, s_stb, s_we}), 128'({e.scyc, e.sstb, e.swe}));
      chk(ph, idx, "m_rsp", 128'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}),
          128'({e.a0, e.e0, e.r0, e.a1, e.e1, e.r1}));
      chk(ph, idx, "s_route", 128'({s_adr, s_dat_ms, s_sel, s_cti, s_bte}), 128'(rexp));
      chk(ph, idx, "m0_dat_sm", 128'(m0_dat_sm), 128'(d0exp));
      chk(ph, idx, "m1_dat_sm", 128'(m1_dat_sm), 128'(d1exp));
   endtask

   initial begin
      logic own1;
      sys_rst_n = 1'b0;
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
      m0_adr = M0_ADR; m0_dat_ms = M0_DAT; m0_sel = M0_SEL; m0_cti = M0_CTI; m0_bte = M0_BTE;
      m1_adr = M1_ADR; m1_dat_ms = M1_DAT; m1_sel = M1_SEL; m1_cti = M1_CTI; m1_bte = M1_BTE;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = S_DAT;
      repeat (2) @(posedge sys_clk);

      // in  = {rst_n, c0 s0 w0, c1 s1 w1, ack err rty}
      // out = {gnt, scyc sstb swe, a0 e0 r0, a1 e1 r1}
      tbl[0]  = mkv(10'b0_000_000_000, 11'b00_000_000_000);
      tbl[1]  = mkv(10'b1_110_110_000, 11'b00_000_000_000);
      tbl[2]  = mkv(10'b1_110_110_100, 11'b01_110_100_000);
      tbl[3]  = mkv(10'b1_000_110_000, 11'b01_000_000_000);
      tbl[4]  = mkv(10'b1_000_110_000, 11'b00_000_000_000);
      tbl[5]  = mkv(10'b1_000_111_100, 11'b10_111_000_100);
      tbl[6]  = mkv(10'b1_110_000_000, 11'b10_000_000_000);
      tbl[7]  = mkv(10'b1_110_110_000, 11'b00_000_000_000);
      tbl[8]  = mkv(10'b1_110_110_110, 11'b01_110_110_000);
      tbl[9]  = mkv(10'b1_110_110_001, 11'b01_110_001_000);
      tbl[10] = mkv(10'b1_100_110_000, 11'b01_100_000_000);
      tbl[11] = mkv(10'b1_010_110_000, 11'b01_000_000_000);
      tbl[12] = mkv(10'b1_000_110_000, 11'b00_000_000_000);
      tbl[13] = mkv(10'b1_110_110_100, 11'b10_110_000_100);
      tbl[14] = mkv(10'b1_110_000_000, 11'b10_000_000_000);
      tbl[15] = mkv(10'b1_110_000_000, 11'b00_000_000_000);
      tbl[16] = mkv(10'b1_000_000_000, 11'b01_000_000_000);
      tbl[17] = mkv(10'b1_000_000_000, 11'b00_000_000_000);
      tbl[18] = mkv(10'b1_010_010_000, 11'b00_000_000_000);
      tbl[19] = mkv(10'b1_000_000_000, 11'b00_000_000_000);
      for (int k = 0; k < 20; k++) begin
         apply("tbl", k, tbl[k]);
      end

      // Round-robin: both masters keep requesting, owners must alternate starting with m1
      for (int i = 0; i < 20; i++) begin
         own1 = (i % 2 == 0);
         apply("rr", 3*i, mkv(10'b1_110_110_000, 11'b00_000_000_000));
         apply("rr", 3*i+1, mkv(10'b1_110_110_100,
               {own1 ? 2'b10 : 2'b01, 3'b110, own1 ? 6'b000_100 : 6'b100_000}));
         apply("rr", 3*i+2, mkv(own1 ? 10'b1_110_000_000 : 10'b1_000_110_000,
               {own1 ? 2'b10 : 2'b01, 9'b0_0000_0000}));
      end

      // m1 8-beat burst while m0 waits
      apply("burst", 0, mkv(10'b1_110_110_000, 11'b00_000_000_000));
      for (int k = 1; k <= 8; k++) begin
         apply("burst", k, mkv(10'b1_110_111_100, 11'b10_111_000_100));
      end
      apply("burst", 9, mkv(10'b1_110_000_000, 11'b10_000_000_000));
      apply("burst", 10, mkv(10'b1_110_000_000, 11'b00_000_000_000));

      // Slave never answers m0: error beat every fifth strobe cycle
      for (int k = 1; k <= 10; k++) begin
         apply("timeout", k, mkv(10'b1_110_000_000,
               (k % 5 == 0) ? 11'b01_000_010_000 : 11'b01_110_000_000));
      end
      apply("timeout", 11, mkv(10'b1_000_000_000, 11'b01_000_000_000));

      // Reset pulse in the middle of an m1 burst
      apply("rst", 0, mkv(10'b1_000_110_000, 11'b00_000_000_000));
      apply("rst", 1, mkv(10'b1_000_110_100, 11'b10_110_000_100));
      apply("rst", 2, mkv(10'b1_000_110_000, 11'b10_110_000_000));
      apply("rst", 3, mkv(10'b0_000_110_100, 11'b10_000_000_000));
      apply("rst", 4, mkv(10'b1_000_110_000, 11'b00_000_000_000));
      apply("rst", 5, mkv(10'b1_000_110_100, 11'b10_110_000_100));
      apply("rst", 6, mkv(10'b1_000_000_000, 11'b10_000_000_000));
      apply("rst", 7, mkv(10'b1_000_000_000, 11'b00_000_000_000));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
